ifetch_queue: RTL and testbench

- Instruction prefetch FIFO between ifetch (producer) and exec (consumer) in the rv32 core.
- Decouples fetch from execute stalls by buffering {pc, instr} pairs in order.
- Flushes all buffered entries when exec redirects the PC via jump_select.
- Exposes occupancy for debug and bench checking.

---
 rtl/ifq_pkg.sv | 18 +
 rtl/ifq_storage.sv | 27 ++
 rtl/ifetch_queue.sv | 107 ++++++++++
 tb/tb_ifetch_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared constants and width helpers for the instruction prefetch queue.
// Optional same-cycle bypass is enabled by defining IFQ_BYPASS_EN.
package ifq_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Pointer width: pointers wrap naturally because DEPTH is a power of two.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit to represent the full state (count == DEPTH).
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Flop-array storage for the prefetch queue: one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch FIFO between ifetch and exec; flushed on jump_select.
// Define IFQ_BYPASS_EN to let an input pair reach the head in the same cycle when empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [XLEN-1:0]                 f_instr_next,
  input  logic [XLEN-1:0]                 f_pc_next,
  output logic                            q_ready,
  output logic                            q_valid,
  output logic [XLEN-1:0]                 q_instr,
  output logic [XLEN-1:0]                 q_pc,
  input  logic                            e_ready,
  input  logic                            jump_select,
  output logic [count_width(DEPTH)-1:0]   q_count
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshakes: a push happens when i_valid & q_ready, a pop when
  // q_valid & e_ready, both taking effect at the next rising clk edge.
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              bypass_hit;
  logic              bypass_take;
  logic              wr_en;
  logic              rd_adv;
  logic [2*XLEN-1:0] wdata;
  logic [2*XLEN-1:0] rdata;

  assign q_ready = !rst && (count != FULL);

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = !rst && !jump_select && i_valid && (count == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign q_valid     = !rst && ((count != '0) || bypass_hit);
  assign push        = i_valid && q_ready;
  assign pop         = q_valid && e_ready;
  // A bypassed pair consumed in the same cycle never touches storage.
  assign bypass_take = bypass_hit && e_ready;
  assign wr_en       = push && !bypass_take && !jump_select;
  assign rd_adv      = pop && !bypass_take;

  assign wdata   = {f_pc_next, f_instr_next};
  assign q_count = rst ? '0 : count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (jump_select) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_adv) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_adv})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    q_instr = XLEN'(NOP_INSTR);
    q_pc    = '0;
    if (bypass_hit) begin
      q_instr = f_instr_next;
      q_pc    = f_pc_next;
    end else if (!rst && (count != '0)) begin
      {q_pc, q_instr} = rdata;
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed scoreboard bench for ifetch_queue (DEPTH=4, XLEN=32); honours IFQ_BYPASS_EN.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [XLEN-1:0] f_instr_next;
  logic [XLEN-1:0] f_pc_next;
  logic            q_ready;
  logic            q_valid;
  logic [XLEN-1:0] q_instr;
  logic [XLEN-1:0] q_pc;
  logic            e_ready;
  logic            jump_select;
  logic [2:0]      q_count;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_illegal = 0;
  int mcount    = 0;
  bit pend_js, pend_acc, pend_pop, pend_byp;
  logic [2*XLEN-1:0] exp_q[$];

  ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .f_instr_next (f_instr_next),
    .f_pc_next    (f_pc_next),
    .q_ready      (q_ready),
    .q_valid      (q_valid),
    .q_instr      (q_instr),
    .q_pc         (q_pc),
    .e_ready      (e_ready),
    .jump_select  (jump_select),
    .q_count      (q_count)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [XLEN-1:0] mk_instr(input logic [XLEN-1:0] pc);
    return {pc[23:0], 8'h13} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: apply inputs just after a rising edge and predict their effect.
  task automatic drive(input logic iv, input logic [XLEN-1:0] pc, input logic er, input logic js);
    i_valid      = iv;
    f_pc_next    = pc;
    f_instr_next = mk_instr(pc);
    e_ready      = er;
    jump_select  = js;
    pend_js  = js;
    pend_acc = iv && !js && (mcount < DEPTH);
    pend_byp = BYP && iv && !js && er && (mcount == 0);
    pend_pop = er && (mcount > 0);
    if (pend_acc) exp_q.push_back({pc, mk_instr(pc)});
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (pend_js) begin
      mcount = 0;
      exp_q.delete();
    end else if (!pend_byp) begin
      mcount = mcount + int'(pend_acc) - int'(pend_pop);
    end
  endtask

  task automatic cyc(input logic iv, input logic [XLEN-1:0] pc, input logic er, input logic js);
    drive(iv, pc, er, js);
    commit();
  endtask

  // Monitor: compare the head whenever it is valid; retire it when consumed.
  always @(negedge clk) begin
    if (!rst && q_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_head", {q_pc, q_instr}, 64'h0);
      end else begin
        check("head_pc", q_pc, exp_q[0][63:32]);
        check("head_instr", q_instr, exp_q[0][31:0]);
        if (e_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Illegal input: i_valid while full (outside reset and flush).
  always @(negedge clk) begin
    if (!rst && !jump_select && i_valid && (q_count == 3'(DEPTH))) begin
      n_illegal++;
      $display("note: i_valid while full at %0t", $time);
    end
  end

  initial begin
    rst = 1'b1; i_valid = 1'b1; f_pc_next = 32'h999; f_instr_next = 32'h1;
    e_ready = 1'b0; jump_select = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q_ready", q_ready, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_count", q_count, 0);
    check("rst_q_instr", q_instr, 32'h13);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    check("post_rst_q_ready", q_ready, 1);
    commit();

    // Fill to DEPTH, then an ignored push while full
    for (int k = 0; k < 4; k++) cyc(1, 32'h40 + 32'(4*k), 0, 0);
    check("full_q_count", q_count, 4);
    check("full_q_ready", q_ready, 0);
    cyc(1, 32'h50, 0, 0);
    check("overfill_q_count", q_count, 4);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0);
    check("drained_q_count", q_count, 0);
    check("drained_q_valid", q_valid, 0);
    check("drained_q_instr", q_instr, 32'h13);

    // Simultaneous push/pop at count 2
    cyc(1, 32'h58, 0, 0);
    cyc(1, 32'h5C, 0, 0);
    cyc(1, 32'h60, 1, 0);
    check("pushpop_q_count", q_count, 2);
    check("pushpop_head", q_pc, 32'h5C);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("pushpop_drained", q_count, 0);

    // Flush at count 3 with a concurrent push that must be discarded
    cyc(1, 32'h70, 0, 0);
    cyc(1, 32'h74, 0, 0);
    cyc(1, 32'h78, 0, 0);
    check("preflush_q_count", q_count, 3);
    cyc(1, 32'h80, 0, 1);
    check("flush_q_count", q_count, 0);
    check("flush_q_valid", q_valid, 0);
    cyc(0, 0, 1, 0);
    check("postflush_q_valid", q_valid, 0);

    // Wrap-around: 10 entries, occupancy held at 1..3
    for (int k = 0; k < 3; k++) cyc(1, 32'h100 + 32'(4*k), 0, 0);
    for (int k = 3; k < 10; k++) cyc(1, 32'h100 + 32'(4*k), 1, 0);
    check("wrap_q_count", q_count, 3);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0);
    check("wrap_drained", q_count, 0);

    // Same-cycle behaviour for a pair arriving at an empty queue
    drive(1, 32'h200, 1, 0);
    #1;
    if (BYP) begin
      check("byp_q_valid", q_valid, 1);
      check("byp_q_pc", q_pc, 32'h200);
      commit();
      check("byp_q_count", q_count, 0);
    end else begin
      check("nobyp_q_valid", q_valid, 0);
      commit();
      check("nobyp_next_q_pc", q_pc, 32'h200);
      check("nobyp_next_q_valid", q_valid, 1);
    end
    drive(0, 0, 1, 0);
    commit();
    check("final_q_count", q_count, 0);
    cyc(0, 0, 0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    check("illegal_push_seen", 64'(n_illegal), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
